// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer: ten-band colour bars with one square sprite overlaid.
// Define VGA_SPRITE_BOUNCE_EN to let the sprite bounce once per frame.
module vga_sprite_renderer #(
    parameter int          H_ACTIVE      = 640,
    parameter int          V_ACTIVE      = 480,
    parameter int          SPRITE_SIZE   = 32,
    parameter int          INIT_X        = 304,
    parameter int          INIT_Y        = 224,
    parameter int          STEP          = 2,
    parameter logic [11:0] SPRITE_COLOUR = 12'h0A5
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic       Sync_Horiz_In,
    input  logic       Sync_Vert_In,
    input  logic       Disp_Ena_In,
    input  logic [9:0] Val_Col_In,
    input  logic [9:0] Val_Row_In,
    output logic       Sync_Horiz_Out,
    output logic       Sync_Vert_Out,
    output logic [3:0] Red_Out,
    output logic [3:0] Green_Out,
    output logic [3:0] Blue_Out,
    output logic       Frame_Tick_Out
);

    localparam logic [10:0] SIZE_W = 11'(SPRITE_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] H_W    = 11'(H_ACTIVE);
    localparam logic [10:0] V_W    = 11'(V_ACTIVE);

    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       vs_prev;
    logic       frame_edge;

    assign frame_edge = vs_prev & ~Sync_Vert_In;

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            vs_prev        <= 1'b1;
            Frame_Tick_Out <= 1'b0;
        end else begin
            vs_prev        <= Sync_Vert_In;
            Frame_Tick_Out <= frame_edge;
        end
    end

`ifdef VGA_SPRITE_BOUNCE_EN
    logic        dir_x;
    logic        dir_y;
    logic [10:0] next_x;
    logic [10:0] next_y;

    // Returns {direction, position}; direction 1 means moving toward zero.
    function automatic logic [10:0] axis_next(
        input logic [9:0]  p,
        input logic        d,
        input logic [10:0] lim
    );
        logic [10:0] p_w;
        p_w = {1'b0, p};
        if (!d) begin
            if (p_w + STEP_W + SIZE_W > lim)
                axis_next = {1'b1, 10'(lim - SIZE_W)};
            else
                axis_next = {1'b0, 10'(p_w + STEP_W)};
        end else if (p_w < STEP_W) begin
            axis_next = {1'b0, 10'd0};
        end else begin
            axis_next = {1'b1, 10'(p_w - STEP_W)};
        end
    endfunction

    assign next_x = axis_next(pos_x, dir_x, H_W);
    assign next_y = axis_next(pos_y, dir_y, V_W);

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            pos_x <= 10'(INIT_X);
            pos_y <= 10'(INIT_Y);
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else if (frame_edge) begin
            {dir_x, pos_x} <= next_x;
            {dir_y, pos_y} <= next_y;
        end
    end
`else
    assign pos_x = 10'(INIT_X);
    assign pos_y = 10'(INIT_Y);
`endif

    logic [10:0] col_w;
    logic [10:0] row_w;
    logic [10:0] x_w;
    logic [10:0] y_w;
    logic        hit;

    assign col_w = {1'b0, Val_Col_In};
    assign row_w = {1'b0, Val_Row_In};
    assign x_w   = {1'b0, pos_x};
    assign y_w   = {1'b0, pos_y};
    assign hit   = (col_w >= x_w) && (col_w < x_w + SIZE_W) &&
                   (row_w >= y_w) && (row_w < y_w + SIZE_W);

    logic       s1_hs;
    logic       s1_vs;
    logic       s1_de;
    logic       s1_hit;
    logic [3:0] s1_bar;

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_de  <= 1'b0;
            s1_hit <= 1'b0;
            s1_bar <= 4'd0;
        end else begin
            s1_hs  <= Sync_Horiz_In;
            s1_vs  <= Sync_Vert_In;
            s1_de  <= Disp_Ena_In;
            s1_hit <= hit;
            s1_bar <= Val_Col_In[9:6];
        end
    end

    logic [11:0] pal;
    logic [11:0] colour;
    logic [11:0] rgb;

    always_comb begin
        pal = 12'h000;
        case (s1_bar)
            4'd0:    pal = 12'h000;
            4'd1:    pal = 12'hF00;
            4'd2:    pal = 12'h0F0;
            4'd3:    pal = 12'h00F;
            4'd4:    pal = 12'hFF0;
            4'd5:    pal = 12'h0FF;
            4'd6:    pal = 12'hF0F;
            4'd7:    pal = 12'hFFF;
            4'd8:    pal = 12'h888;
            4'd9:    pal = 12'h444;
            default: pal = 12'h000;
        endcase
    end

    always_comb begin
        colour = 12'h000;
        if (s1_de)
            colour = s1_hit ? SPRITE_COLOUR : pal;
    end

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            rgb            <= 12'h000;
            Sync_Horiz_Out <= 1'b1;
            Sync_Vert_Out  <= 1'b1;
        end else begin
            rgb            <= colour;
            Sync_Horiz_Out <= s1_hs;
            Sync_Vert_Out  <= s1_vs;
        end
    end

    assign Red_Out   = rgb[11:8];
    assign Green_Out = rgb[7:4];
    assign Blue_Out  = rgb[3:0];

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// tb_vga_sprite_renderer: vector table, directed corner sequences and
// randomized pixels against a per-frame position model.
module tb_vga_sprite_renderer;

`ifdef VGA_SPRITE_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif
    localparam int SZ   = 32;
    localparam int STP  = 2;
    localparam int HACT = 640;
    localparam int VACT = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       hs_in = 1'b1;
    logic       vs_in = 1'b1;
    logic       de_in = 1'b0;
    logic [9:0] col_in = '0;
    logic [9:0] row_in = '0;

    logic       hs_o [2];
    logic       vs_o [2];
    logic [3:0] r_o [2];
    logic [3:0] g_o [2];
    logic [3:0] b_o [2];
    logic       tick_o [2];

    always #20 clk = ~clk;

    vga_sprite_renderer u_dut (
        .Master_Clock_In(clk),
        .Reset_N_In     (rst_n),
        .Sync_Horiz_In  (hs_in),
        .Sync_Vert_In   (vs_in),
        .Disp_Ena_In    (de_in),
        .Val_Col_In     (col_in),
        .Val_Row_In     (row_in),
        .Sync_Horiz_Out (hs_o[0]),
        .Sync_Vert_Out  (vs_o[0]),
        .Red_Out        (r_o[0]),
        .Green_Out      (g_o[0]),
        .Blue_Out       (b_o[0]),
        .Frame_Tick_Out (tick_o[0])
    );

    vga_sprite_renderer #(.INIT_X(607), .INIT_Y(447)) u_crn (
        .Master_Clock_In(clk),
        .Reset_N_In     (rst_n),
        .Sync_Horiz_In  (hs_in),
        .Sync_Vert_In   (vs_in),
        .Disp_Ena_In    (de_in),
        .Val_Col_In     (col_in),
        .Val_Row_In     (row_in),
        .Sync_Horiz_Out (hs_o[1]),
        .Sync_Vert_Out  (vs_o[1]),
        .Red_Out        (r_o[1]),
        .Green_Out      (g_o[1]),
        .Blue_Out       (b_o[1]),
        .Frame_Tick_Out (tick_o[1])
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %03h expected %03h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] rgb_of(input int d);
        return {r_o[d], g_o[d], b_o[d]};
    endfunction

    logic [11:0] pal [10] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                              12'h0FF, 12'hF0F, 12'hFFF, 12'h888, 12'h444};
    int ix [2] = '{304, 607};
    int iy [2] = '{224, 447};

    // Reference model state
    int          mx [2];
    int          my [2];
    bit          mdx [2];
    bit          mdy [2];
    bit          vsp;
    logic [11:0] pend_rgb [2];
    bit          pend_hs;
    bit          pend_vs;

    function automatic logic [11:0] colour(input int c, input int r,
                                           input bit de, input int x,
                                           input int y);
        if (!de) return 12'h000;
        if (c >= x && c < x + SZ && r >= y && r < y + SZ) return 12'h0A5;
        if (c / 64 < 10) return pal[c / 64];
        return 12'h000;
    endfunction

    task automatic move(input int d);
        if (!mdx[d]) begin
            if (mx[d] + STP + SZ > HACT) begin mx[d] = HACT - SZ; mdx[d] = 1; end
            else mx[d] = mx[d] + STP;
        end else begin
            if (mx[d] < STP) begin mx[d] = 0; mdx[d] = 0; end
            else mx[d] = mx[d] - STP;
        end
        if (!mdy[d]) begin
            if (my[d] + STP + SZ > VACT) begin my[d] = VACT - SZ; mdy[d] = 1; end
            else my[d] = my[d] + STP;
        end else begin
            if (my[d] < STP) begin my[d] = 0; mdy[d] = 0; end
            else my[d] = my[d] - STP;
        end
    endtask

    task automatic cycle();
        logic [11:0] nrgb [2];
        bit e;
        for (int d = 0; d < 2; d++)
            nrgb[d] = colour(int'(col_in), int'(row_in), de_in, mx[d], my[d]);
        e = vsp && !vs_in;
        if (e && BOUNCE) begin
            move(0);
            move(1);
        end
        vsp = vs_in;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rgb%0d", d), rgb_of(d), pend_rgb[d]);
            chk($sformatf("hs%0d", d), 12'(hs_o[d]), 12'(pend_hs));
            chk($sformatf("vs%0d", d), 12'(vs_o[d]), 12'(pend_vs));
            chk($sformatf("tick%0d", d), 12'(tick_o[d]), 12'(e));
        end
        pend_rgb = nrgb;
        pend_hs  = hs_in;
        pend_vs  = vs_in;
    endtask

    task automatic chk_reset_vals(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_rgb"}, rgb_of(d), 12'h000);
            chk({nm, "_hs"}, 12'(hs_o[d]), 12'h1);
            chk({nm, "_vs"}, 12'(vs_o[d]), 12'h1);
            chk({nm, "_tick"}, 12'(tick_o[d]), 12'h0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        for (int d = 0; d < 2; d++) begin
            mx[d] = ix[d]; my[d] = iy[d];
            mdx[d] = 0; mdy[d] = 0;
            pend_rgb[d] = 12'h000;
        end
        vsp = 1; pend_hs = 1; pend_vs = 1;
        repeat (3) begin
            col_in = 10'($urandom);
            row_in = 10'($urandom);
            de_in  = 1'($urandom);
            hs_in  = 1'($urandom);
            vs_in  = 1'($urandom);
            @(posedge clk);
            #1;
            chk_reset_vals("rst_hold");
        end
        hs_in = 1'b1;
        vs_in = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic probe(input int c, input int r);
        col_in = 10'(c);
        row_in = 10'(r);
        de_in  = 1'b1;
        hs_in  = 1'b1;
        vs_in  = 1'b1;
        cycle();
        cycle();
    endtask

    typedef struct {
        int          col;
        int          row;
        bit          de;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{100, 10, 1'b1, 1'b1, 1'b1, 12'hF00};
        tbl[1]  = '{304, 224, 1'b1, 1'b1, 1'b1, 12'h0A5};
        tbl[2]  = '{335, 255, 1'b1, 1'b1, 1'b1, 12'h0A5};
        tbl[3]  = '{336, 224, 1'b1, 1'b1, 1'b1, 12'h0FF};
        tbl[4]  = '{304, 256, 1'b1, 1'b1, 1'b1, 12'hFF0};
        tbl[5]  = '{303, 224, 1'b1, 1'b1, 1'b1, 12'hFF0};
        tbl[6]  = '{304, 224, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[7]  = '{0, 0, 1'b1, 1'b1, 1'b1, 12'h000};
        tbl[8]  = '{128, 0, 1'b1, 1'b1, 1'b1, 12'h0F0};
        tbl[9]  = '{192, 0, 1'b1, 1'b1, 1'b1, 12'h00F};
        tbl[10] = '{384, 0, 1'b1, 1'b1, 1'b1, 12'hF0F};
        tbl[11] = '{448, 0, 1'b1, 1'b1, 1'b1, 12'hFFF};
        tbl[12] = '{512, 0, 1'b1, 1'b1, 1'b1, 12'h888};
        tbl[13] = '{639, 479, 1'b1, 1'b1, 1'b1, 12'h444};
        tbl[14] = '{700, 10, 1'b1, 1'b1, 1'b1, 12'h000};
        tbl[15] = '{1023, 10, 1'b1, 1'b1, 1'b1, 12'h000};
        tbl[16] = '{100, 10, 1'b1, 1'b0, 1'b1, 12'hF00};
        tbl[17] = '{0, 10, 1'b0, 1'b0, 1'b0, 12'h000};

        #5;
        do_reset();

        for (int i = 0; i < 18; i++) begin
            col_in = 10'(tbl[i].col);
            row_in = 10'(tbl[i].row);
            de_in  = tbl[i].de;
            hs_in  = tbl[i].hs;
            vs_in  = tbl[i].vs;
            cycle();
            cycle();
            chk($sformatf("vec%0d_rgb", i), rgb_of(0), tbl[i].rgb);
            chk($sformatf("vec%0d_hs", i), 12'(hs_o[0]), 12'(tbl[i].hs));
            chk($sformatf("vec%0d_vs", i), 12'(vs_o[0]), 12'(tbl[i].vs));
        end

        // Frame edges on the corner instance
        do_reset();
        probe(0, 0);
        vs_in = 1'b0;
        cycle();
        chk("tick_pulse", 12'(tick_o[1]), 12'h1);
        cycle();
        chk("tick_single", 12'(tick_o[1]), 12'h0);
        probe(607, 447);
        chk("edge1_old_corner", rgb_of(1), BOUNCE ? 12'h444 : 12'h0A5);
        probe(639, 479);
        chk("edge1_new_corner", rgb_of(1), BOUNCE ? 12'h0A5 : 12'h444);
        vs_in = 1'b0;
        cycle();
        chk("tick_pulse2", 12'(tick_o[1]), 12'h1);
        probe(606, 446);
        chk("edge2_left_top", rgb_of(1), BOUNCE ? 12'h0A5 : 12'h444);
        probe(638, 477);
        chk("edge2_right_excl", rgb_of(1), BOUNCE ? 12'h444 : 12'h0A5);

        // Randomized pixels with occasional vsync pulses
        for (int n = 0; n < 1500; n++) begin
            int c;
            int r;
            if ($urandom_range(0, 1) == 1) begin
                c = mx[0] + int'($urandom_range(0, 40)) - 4;
                r = my[0] + int'($urandom_range(0, 40)) - 4;
                if (c < 0) c = 0;
                if (r < 0) r = 0;
            end else begin
                c = int'($urandom_range(0, 1023));
                r = int'($urandom_range(0, 524));
            end
            col_in = 10'(c);
            row_in = 10'(r);
            de_in  = ($urandom_range(0, 3) != 0);
            hs_in  = 1'($urandom);
            vs_in  = ($urandom_range(0, 19) != 0);
            cycle();
        end

        // Reset while sprite pixels stream
        probe(mx[0], my[0]);
        chk("stream_sprite", rgb_of(0), 12'h0A5);
        col_in = 10'(mx[0] + 1);
        cycle();
        do_reset();
        probe(304, 224);
        chk("post_reset_pos0", rgb_of(0), 12'h0A5);
        probe(607, 447);
        chk("post_reset_pos1", rgb_of(1), 12'h0A5);
        probe(100, 10);
        chk("post_reset_bar1", rgb_of(0), 12'hF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sprite_renderer.md
# vga_sprite_renderer

Pixel-colour stage that sits directly downstream of the VGA timing controller. It consumes the controller's sync pulses, display-enable and column/row position, and produces 4:4:4 RGB plus sync outputs re-aligned to the colour pipeline. The picture is a ten-band colour-bar background with one square sprite overlaid. Sprite position updates once per frame, at the start of the vertical sync pulse.

## Interface
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- SPRITE_SIZE, 32, sprite edge length in pixels
- INIT_X, 304, sprite left column after reset
- INIT_Y, 224, sprite top row after reset
- STEP, 2, pixels moved per frame on each axis
- SPRITE_COLOUR, 12'h0A5, sprite RGB as {R,G,B}

Ports:
- Master_Clock_In  in  1  pixel clock (25 MHz); all state on its rising edge
- Reset_N_In  in  1  reset; one clock, reset asynchronous, active-low
- Sync_Horiz_In  in  1  horizontal sync from the timing controller, active-low
- Sync_Vert_In  in  1  vertical sync from the timing controller, active-low
- Disp_Ena_In  in  1  high while the current position is visible
- Val_Col_In  in  10  current column
- Val_Row_In  in  10  current row
- Sync_Horiz_Out  out  1  Sync_Horiz_In delayed 2 cycles
- Sync_Vert_Out  out  1  Sync_Vert_In delayed 2 cycles
- Red_Out, Green_Out, Blue_Out  out  4 each  pixel colour
- Frame_Tick_Out  out  1  one-cycle pulse per frame update

## Operation
- **Stage 1 (registered):**
  - Captures syncs, Disp_Ena_In, col and row.
  - Computes sprite hit: `col >= X && col < X+SPRITE_SIZE && row >= Y && row < Y+SPRITE_SIZE`.
  - All sums are 11 bits wide, so there is no wrap.
  - Computes bar index = col[9:6] (values 0..9).
- **Stage 2 (registered):** colour select.
  - Disp_Ena low gives 12'h000.
  - Otherwise, a sprite hit gives SPRITE_COLOUR.
  - Otherwise the bar palette applies. Bars 0..9 = 000, F00, 0F0, 00F, FF0, 0FF, F0F, FFF, 888, 444.
  - Bar index above 9 gives 000.
- **Frame edge:**
  - The previous Sync_Vert_In is registered.
  - A falling edge (prev=1, cur=0) is the frame edge.
  - On that edge, position registers X/Y and direction bits DX/DY update in one clock, and Frame_Tick_Out is high the following cycle, for 1 cycle.
- **Per-axis update, X shown (Y identical, with V_ACTIVE):**
  - DX=+ and X+STEP+SPRITE_SIZE > H_ACTIVE: X = H_ACTIVE−SPRITE_SIZE, DX flips to −.
  - DX=− and X < STEP: X = 0, DX flips to +.
  - Else X = X ± STEP.
- **Corners:** both axes are evaluated independently in the same cycle, so both directions may flip together.
- **Update timing:** the update happens during vertical blanking, so a visible frame always uses a single position.

## Timing
- Latency from inputs to RGB and to Sync_*_Out is exactly 2 cycles, with identical delay for all outputs.
- **Reset values (asynchronous):**
  - RGB 0 and Frame_Tick_Out 0.
  - Sync_Horiz_Out and Sync_Vert_Out 1 (inactive).
  - Pipeline Disp_Ena 0 and previous vsync 1.
  - X=INIT_X, Y=INIT_Y, DX=+, DY=+.
- **Reset mid-frame:** outputs go to reset values immediately. The first valid pixel appears 2 cycles after the first post-reset input.
- **Stale edge after reset:** no frame edge is detected if vsync is already low at reset release, because previous vsync resets to 1.
- **Sprite-hit timing:** the hit uses the X/Y value registered at stage 1. A frame edge coinciding with a visible pixel cannot occur with legal timing, and is not required to be glitch-free.

## Configuration
- Macro: VGA_SPRITE_BOUNCE_EN.
- **Defined:** motion as described above, with Frame_Tick_Out pulsing per frame.
- **Undefined:**
  - X/Y are held at INIT_X/INIT_Y and no direction state exists.
  - Frame_Tick_Out still pulses on every vsync falling edge.
  - Rendering and latency are unchanged.

## Test plan
- **Reset:** hold Reset_N_In=0 with random inputs -> RGB=000, Sync_*_Out=1, Frame_Tick_Out=0. Release and drive col=100, row=10, Disp_Ena=1 -> two cycles later RGB=F00.
- **Sprite overlay:** col=304, row=224, Disp_Ena=1 after reset -> RGB=0A5 at +2 cycles. col=336 -> bar 5 colour 0FF, since the sprite right edge is exclusive.
- **Blanking:** Disp_Ena=0 at col=304, row=224 -> RGB=000. Syncs toggled -> Sync_*_Out mirror the inputs exactly 2 cycles later.
- **Bounce (VGA_SPRITE_BOUNCE_EN, INIT_X=607, INIT_Y=0):**
  - First vsync falling edge -> X=608, DX=−, Y=2.
  - Second edge -> X=606.
  - Frame_Tick_Out is a single cycle per edge.
- **Corner:** INIT_X=607, INIT_Y=447 -> after one edge X=608, Y=448, and both directions flip.
- **Mid-frame reset:** assert reset while sprite pixels are streaming -> RGB=000 within the same cycle, and the position returns to INIT.
